// File: rtl/control_pkg.sv
// Shared types and constants for the multicycle sequencer.
// States, opcodes and ALU operation-class encodings.
package control_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERROR
  } estado_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [1:0] HAB_R = 2'b00;
  localparam logic [1:0] HAB_I = 2'b01;

  function automatic logic es_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW,
      OP_ADDI, OP_ANDI, OP_ORI: es_legal = 1'b1;
      default:                  es_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_multiciclo_if.sv
// Control bundle between sequencer, instruction register and datapath.
// slave = sequencer side, master = environment side.
interface control_multiciclo_if;

  logic        inicio;
  logic        detener;
  logic [5:0]  oper_in;
  logic        mem_listo;
  logic        w_e_pc;
  logic        w_e_ir;
  logic        w_e_banco;
  logic        w_e_memo;
  logic        r_e_memo;
  logic [1:0]  habilitador;
  logic        signal_MUX_F;
  logic        MUX_INS;
  logic        MUX_D_A;
  logic        ocupado;
  logic        error;
  logic [31:0] cont_instr;

  modport slave (
    input  inicio, detener, oper_in, mem_listo,
    output w_e_pc, w_e_ir, w_e_banco, w_e_memo,
    output r_e_memo, habilitador, signal_MUX_F,
    output MUX_INS, MUX_D_A, ocupado, error,
    output cont_instr
  );

  modport master (
    output inicio, detener, oper_in, mem_listo,
    input  w_e_pc, w_e_ir, w_e_banco, w_e_memo,
    input  r_e_memo, habilitador, signal_MUX_F,
    input  MUX_INS, MUX_D_A, ocupado, error,
    input  cont_instr
  );

endinterface

// File: rtl/control_multiciclo_contador_espera.sv
// MEM wait counter: counts MEM cycles without mem_listo.
// expirado flags the last allowed cycle.
module contador_espera #(
  parameter int unsigned TO_CICLOS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expirado
);

  localparam int unsigned W = $clog2(TO_CICLOS + 1);
  localparam logic [W-1:0] LIM = W'(TO_CICLOS - 1);

  logic [W-1:0] cnt;

  // Count while enabled, restart whenever cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expirado = (cnt == LIM);

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// timeout, sticky error and retired-instruction counter.
import control_pkg::*;

module control_multiciclo #(
  parameter int unsigned TO_CICLOS = 16
) (
  input logic                 clk,
  input logic                 rst,
  control_multiciclo_if.slave bus
);

  estado_t     est;
  logic [5:0]  op_q;
  logic [31:0] cont_q;
  logic        expirado;
  logic        en_mem;

  assign en_mem = (est == S_MEM);

  contador_espera #(.TO_CICLOS(TO_CICLOS)) u_espera (
    .clk      (clk),
    .rst      (rst),
    .clr      (!en_mem),
    .en       (en_mem),
    .expirado (expirado)
  );

  // Sequencer state, latched opcode and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est    <= S_IDLE;
      op_q   <= '0;
      cont_q <= '0;
    end else begin
      unique case (est)
        S_IDLE:   if (bus.inicio) est <= S_FETCH;
        S_FETCH:  est <= S_DECODE;
        S_DECODE: begin
          op_q <= bus.oper_in;
          est  <= es_legal(bus.oper_in) ? S_EXEC : S_ERROR;
        end
        S_EXEC: begin
          if (op_q == OP_LW || op_q == OP_SW) est <= S_MEM;
          else                                est <= S_WB;
        end
        S_MEM: begin
          if (bus.mem_listo) begin
            if (op_q == OP_SW) begin
              cont_q <= cont_q + 32'd1;
              est    <= bus.detener ? S_IDLE : S_FETCH;
            end else begin
              est <= S_WB;
            end
          end else if (expirado) begin
            est <= S_ERROR;
          end
        end
        S_WB: begin
          cont_q <= cont_q + 32'd1;
          est    <= bus.detener ? S_IDLE : S_FETCH;
        end
        S_ERROR:  est <= S_ERROR;
        default:  est <= S_IDLE;
      endcase
    end
  end

  // Moore decode of state and latched opcode; sw retire gated by mem_listo
  always_comb begin
    bus.w_e_pc       = 1'b0;
    bus.w_e_ir       = 1'b0;
    bus.w_e_banco    = 1'b0;
    bus.w_e_memo     = 1'b0;
    bus.r_e_memo     = 1'b0;
    bus.habilitador  = HAB_R;
    bus.signal_MUX_F = 1'b0;
    bus.MUX_INS      = 1'b0;
    bus.MUX_D_A      = 1'b0;
    if (est == S_EXEC || est == S_MEM || est == S_WB) begin
      bus.habilitador = (op_q == OP_R) ? HAB_R : HAB_I;
      bus.MUX_INS     = (op_q != OP_R);
      bus.MUX_D_A     = (op_q == OP_SW);
    end
    unique case (1'b1)
      (est == S_FETCH): bus.w_e_ir = 1'b1;
      (est == S_MEM): begin
        bus.r_e_memo = (op_q == OP_LW);
        bus.w_e_memo = (op_q == OP_SW);
        bus.w_e_pc   = (op_q == OP_SW) && bus.mem_listo;
      end
      (est == S_WB): begin
        bus.w_e_banco    = 1'b1;
        bus.w_e_pc       = 1'b1;
        bus.signal_MUX_F = (op_q == OP_LW);
      end
      default: ;
    endcase
  end

  assign bus.ocupado    = (est != S_IDLE) && (est != S_ERROR);
  assign bus.error      = (est == S_ERROR);
  assign bus.cont_instr = cont_q;

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multicycle sequencer for the processor datapath. It replaces single-cycle decoding by stepping each instruction through FETCH, DECODE, EXEC, MEM and WB. In each step it drives the same datapath enables and mux selects as the combinational decoder, plus PC/IR write enables, a data-memory handshake with timeout, and a retired-instruction counter. It sits between the instruction register and the datapath: register bank, ALU, data memory, and the ALU-input, address and write-back muxes.

## Interface
- TO_CICLOS, 16: maximum MEM wait cycles without `mem_listo` before entering ERROR; ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- inicio  in  1  start request; honoured only in IDLE.
- detener  in  1  stop request; sampled on the last cycle of an instruction.
- oper_in  in  6  opcode field of the instruction register.
- mem_listo  in  1  data memory done/ready; meaningful only in MEM.
- w_e_pc  out  1  PC write enable.
- w_e_ir  out  1  instruction register write enable.
- w_e_banco  out  1  register bank write enable.
- w_e_memo  out  1  data memory write enable.
- r_e_memo  out  1  data memory read enable.
- habilitador  out  2  ALU operation class.
- signal_MUX_F  out  1  write-back select: 1 = memory data, 0 = ALU.
- MUX_INS  out  1  ALU B select: 1 = immediate, 0 = register.
- MUX_D_A  out  1  store-data path select.
- ocupado  out  1  1 in every state except IDLE and ERROR.
- error  out  1  sticky fault flag; cleared only by `rst`.
- cont_instr  out  32  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR.
- Legal opcodes:
  - 000000 R-type
  - 100011 lw
  - 101011 sw
  - 001000 addi
  - 001100 andi
  - 001101 ori
- IDLE:
  - `inicio`=1 → FETCH.
  - All outputs 0.
- FETCH:
  - `w_e_ir`=1 for one cycle.
  - Next state DECODE.
- DECODE:
  - Latch `oper_in` into `op_q`.
  - Legal opcode → EXEC.
  - Illegal opcode → ERROR.
- EXEC (one cycle):
  - lw or sw → MEM.
  - All other legal opcodes → WB.
- Datapath controls (EXEC, MEM, WB), decoded from `op_q`:
  - `habilitador`=00 for R-type, 01 for all other legal opcodes.
  - `MUX_INS`=1 for every opcode except R-type.
  - `MUX_D_A`=1 only for sw.
  - These controls are 0 in IDLE, FETCH, DECODE and ERROR.
- MEM:
  - lw holds `r_e_memo`=1; sw holds `w_e_memo`=1, until `mem_listo`.
  - On `mem_listo`, lw → WB.
  - On `mem_listo`, sw retires: `w_e_pc`=1 that cycle and `cont_instr` increments. Next state is FETCH, or IDLE if `detener`=1.
- Timeout:
  - The wait counter clears on MEM entry.
  - `mem_listo` absent for TO_CICLOS consecutive MEM cycles → ERROR.
  - `mem_listo` on the final allowed cycle wins over the timeout.
- WB (one cycle):
  - `w_e_banco`=1.
  - `signal_MUX_F`=1 for lw, 0 otherwise.
  - `w_e_pc`=1.
  - `cont_instr` increments, wrapping 2^32-1 → 0.
  - `detener`=1 → IDLE, else FETCH.
- ERROR:
  - `error`=1, every other control output 0.
  - Held until `rst`; `inicio` is ignored.
- `mem_listo` outside MEM and `inicio` outside IDLE are ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including `cont_instr`=0 and `error`=0.
  - `op_q`=0, wait counter 0.
- Reset asserted mid-instruction:
  - All enables drop immediately (asynchronously).
  - Partial stores are aborted with no PC update.
- All outputs are registered-state Moore decodes with no combinational path from inputs. The `mem_listo`-gated `w_e_pc` for sw is the only exception.
- Latency, from the FETCH cycle through the retiring cycle:
  - R-type/addi/andi/ori: 4 cycles.
  - lw: 5 + w cycles.
  - sw: 4 + w cycles.
  - w is the number of MEM cycles before `mem_listo`.
- `inicio` seen in IDLE at edge n → FETCH at n+1.
- The opcode is sampled only in DECODE; `oper_in` changes after DECODE have no effect.

## Structure
- Package `control_pkg` holds:
  - The state enum.
  - The six opcode constants.
  - The `habilitador` encodings (00, 01).
- One sub-module, `contador_espera`: parametrised TO_CICLOS wait counter. It has clear and enable inputs and an `expirado` output, and its width is $clog2(TO_CICLOS+1).
- The top level holds the FSM, the `op_q` register, output decode and `cont_instr`.

## Test plan
- **addi, no detener:** `inicio`, opcode 001000 → `w_e_ir` at cycle 1, `MUX_INS`=1 and `habilitador`=01 at cycles 3–4, `w_e_banco`=`w_e_pc`=1 at cycle 4, `cont_instr`=1, state back in FETCH.
- **lw, 2 wait cycles:** opcode 100011, `mem_listo` on the 3rd MEM cycle → `r_e_memo` high 3 cycles, then WB with `signal_MUX_F`=1 and `w_e_banco`=1; total 7 cycles.
- **sw with detener:** opcode 101011, immediate `mem_listo`, `detener`=1 → `w_e_memo`=`MUX_D_A`=1 for one cycle, `w_e_pc`=1, `w_e_banco` never asserted, next state IDLE, `ocupado`=0.
- **Illegal opcode:** 111111 → ERROR after DECODE, `error`=1 and all enables 0; `inicio` pulses ignored until `rst`.
- **Timeout boundary:** TO_CICLOS=4.
  - No `mem_listo` → ERROR after 4 MEM cycles.
  - Repeat with `mem_listo` on the 4th MEM cycle → completes normally.
- **Reset mid-MEM, then counter wrap:** assert `rst` during an sw wait → all outputs 0 immediately, `cont_instr`=0. Then force the counter to 32'hFFFFFFFF, retire one R-type → `cont_instr`=0.
